shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter: WIDTH, default 4, the width of the controlled shift register and of data_in, q_fb, p and result.
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: start  in  1  request strobe; sampled only in IDLE.
REQ-006 Port: clr_req  in  1  request to clear the register; sampled only in IDLE.
REQ-007 Port: data_in  in  WIDTH  operand, captured with start.
REQ-008 Port: dir  in  1  shift direction (0 left, 1 right), captured with start.
REQ-009 Port: amount  in  3  shift count 0..7, captured with start.
REQ-010 Port: fill  in  2  fill mode (00 zero, 01 one, 10 rotate, 11 arithmetic), captured with start.
REQ-011 Port: q_fb  in  WIDTH  register output feedback (q of the controlled shifter).
REQ-012 Port: s  out  2  mode select (00 hold, 01 shift right, 10 shift left, 11 parallel load).
REQ-013 Port: p  out  WIDTH  parallel load data.
REQ-014 Port: sil / sir  out  1 each  serial-in for left / right shift.
REQ-015 Port: clear_n  out  1  active-low register clear.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: done  out  1  one-cycle completion pulse; result  out  WIDTH  equals q_fb while done is high.

Function
REQ-018 Shifter convention: s=01 gives q[i] <= q[i+1] and q[WIDTH-1] <= sir; s=10 gives q[i] <= q[i-1] and q[0] <= sil.
REQ-019 States SHALL be CLR, IDLE, LOAD, SHIFT and DONE; outputs s, p, sil, sir, clear_n, busy and done SHALL be decoded from the registered state only.
REQ-020 CLR: clear_n=0 and s=00 for exactly one cycle, then IDLE.
REQ-021 IDLE: s=00, clear_n=1; clr_req=1 goes to CLR; otherwise start=1 captures data_in, dir, amount and fill, then goes to LOAD.
REQ-022 LOAD: s=11 and p=captured data for one cycle; next state is SHIFT if amount>0, else DONE.
REQ-023 SHIFT: s=01 (dir=1) or 10 (dir=0) for exactly amount cycles, counted by a 3-bit down-counter; then DONE.
REQ-024 Serial input during SHIFT: zero fill drives 0; one fill drives 1; rotate drives sir=q_fb[0] and sil=q_fb[WIDTH-1]; arithmetic drives sir=q_fb[WIDTH-1] and sil=0; the unused serial input is 0.
REQ-025 DONE: s=00, done=1, result=q_fb for one cycle, then IDLE.
REQ-026 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+amount+1 (amount=0 gives done 2 cycles after E0).
REQ-027 If start and clr_req are both high in IDLE, clr_req SHALL win and start SHALL be dropped.
REQ-028 start and clr_req outside IDLE SHALL be ignored and not queued; captured operands SHALL be stable while busy.
REQ-029 amount greater than WIDTH SHALL be executed literally (e.g. 5 rotates of WIDTH=4 equal 1 rotate); there is no saturation.
REQ-030 When not in SHIFT, p SHALL hold the last captured data and sil/sir SHALL be 0.

Reset
REQ-031 rst=1 at a clock edge SHALL force state CLR, clear the counter and captured operands to 0, and give busy=1, done=0, s=00 and clear_n=0 in the following cycle; IDLE follows one cycle after rst is released.
REQ-032 rst SHALL override any in-progress operation; no done pulse is produced for an aborted operation.

Verification (bench instantiates ls74194-style model on s/p/sil/sir/clear_n/q_fb)
REQ-033 Reset then idle -> q_fb=0000, busy=0, done=0, s=00.
REQ-034 start, data_in=1010, dir=1, amount=1, fill=00 -> done 3 cycles after start, result=0101.
REQ-035 data_in=1001, dir=0, amount=2, fill=10 -> result=0110; busy high for exactly 4 cycles.
REQ-036 data_in=1000, dir=1, amount=3, fill=11 -> result=1111; data_in=0011, dir=0, amount=0 -> result=0011 with done 2 cycles after start.
REQ-037 start and clr_req together in IDLE -> CLR taken, q_fb=0000, no done pulse; start pulsed during SHIFT -> ignored.
REQ-038 rst asserted mid-SHIFT -> no done pulse, clear_n=0 the next cycle, q_fb=0000, then IDLE.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Handshake and shifter-control bundle between the sequencer and its
// requester / controlled ls74194-style shift register.
interface shift_sequencer_if #(parameter int WIDTH = 4);
  logic             start;
  logic             clr_req;
  logic [WIDTH-1:0] data_in;
  logic             dir;
  logic [2:0]       amount;
  logic [1:0]       fill;
  logic [WIDTH-1:0] q_fb;
  logic [1:0]       s;
  logic [WIDTH-1:0] p;
  logic             sil;
  logic             sir;
  logic             clear_n;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, clr_req, data_in, dir, amount, fill, q_fb,
    input  s, p, sil, sir, clear_n, busy, done, result
  );

  modport slave (
    input  start, clr_req, data_in, dir, amount, fill, q_fb,
    output s, p, sil, sir, clear_n, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencer driving a 4-mode universal shift register: clear, load, shift N, report.
//
// state | meaning
// CLR   | clear_n low for one cycle, register forced to zero
// IDLE  | waiting for clr_req or start
// LOAD  | parallel load of captured operand (s=11)
// SHIFT | shift for the captured amount, counted down
// DONE  | one-cycle done pulse, result mirrors q_fb
module shift_sequencer #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_CLR   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [1:0]       fill_q, fill_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    case (state_q)
      ST_CLR:  state_d = ST_IDLE;
      ST_IDLE: begin
        // clr_req has priority; a simultaneous start is dropped
        if (bus.clr_req) begin
          state_d = ST_CLR;
        end else if (bus.start) begin
          data_d  = bus.data_in;
          dir_d   = bus.dir;
          fill_d  = bus.fill;
          cnt_d   = bus.amount;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:  state_d = (cnt_q != 3'd0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLR;
      cnt_q   <= 3'd0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    bus.s       = 2'b00;
    bus.clear_n = (state_q != ST_CLR);
    bus.busy    = (state_q != ST_IDLE);
    bus.done    = (state_q == ST_DONE);
    bus.result  = (state_q == ST_DONE) ? bus.q_fb : '0;
    bus.p       = data_q;
    bus.sil     = 1'b0;
    bus.sir     = 1'b0;
    case (state_q)
      ST_LOAD:  bus.s = 2'b11;
      ST_SHIFT: begin
        bus.s = dir_q ? 2'b01 : 2'b10;
        // only the serial input on the active side is ever non-zero
        case (fill_q)
          2'b01: begin
            bus.sir = dir_q;
            bus.sil = ~dir_q;
          end
          2'b10: begin
            bus.sir = dir_q & bus.q_fb[0];
            bus.sil = ~dir_q & bus.q_fb[WIDTH-1];
          end
          2'b11: bus.sir = dir_q & bus.q_fb[WIDTH-1];
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
